// File: rtl/operand_fetch.sv
// operand_fetch: issue stage that reads the regfile, bypasses writeback data, tracks pending rd in a scoreboard and presents operand bundles to execute.
// Optional macro OPFETCH_WB_BYPASS_EN: forward the current writeback to operands and release hazards in the writeback cycle.
module operand_fetch #(
    parameter int ADDR_SIZE = 5,
    parameter int CELL_SIZE = 32,
    parameter int TAG_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_SIZE-1:0] in_rs1,
    input  logic [ADDR_SIZE-1:0] in_rs2,
    input  logic [ADDR_SIZE-1:0] in_rd,
    input  logic                 in_rd_we,
    input  logic [TAG_W-1:0]     in_tag,
    output logic [ADDR_SIZE-1:0] rf_r1,
    output logic [ADDR_SIZE-1:0] rf_r2,
    input  logic [CELL_SIZE-1:0] rf_r1data,
    input  logic [CELL_SIZE-1:0] rf_r2data,
    input  logic                 wb_valid,
    input  logic [ADDR_SIZE-1:0] wb_rd,
    input  logic [CELL_SIZE-1:0] wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CELL_SIZE-1:0] out_rs1data,
    output logic [CELL_SIZE-1:0] out_rs2data,
    output logic [ADDR_SIZE-1:0] out_rd,
    output logic                 out_rd_we,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int NREG = 2 ** ADDR_SIZE;
`ifdef OPFETCH_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                 s1_valid_q, s1_valid_d;
    logic [ADDR_SIZE-1:0] s1_rs1_q, s1_rs2_q, s1_rd_q;
    logic                 s1_rd_we_q;
    logic [TAG_W-1:0]     s1_tag_q;
    logic [NREG-1:0]      pending_q, pending_d;
    logic                 lw_valid_q;
    logic [ADDR_SIZE-1:0] lw_rd_q;
    logic [CELL_SIZE-1:0] lw_data_q;
    logic                 cn1, cn2, cnd, lw1, lw2, hazard, issue, load;

    // Hazard detection, operand select, handshake and regfile addressing
    always_comb begin
        cn1         = BYPASS && wb_valid && (wb_rd == s1_rs1_q);
        cn2         = BYPASS && wb_valid && (wb_rd == s1_rs2_q);
        cnd         = BYPASS && wb_valid && (wb_rd == s1_rd_q);
        lw1         = lw_valid_q && (lw_rd_q == s1_rs1_q);
        lw2         = lw_valid_q && (lw_rd_q == s1_rs2_q);
        hazard      = ((s1_rs1_q != '0) && pending_q[s1_rs1_q] && !cn1) ||
                      ((s1_rs2_q != '0) && pending_q[s1_rs2_q] && !cn2) ||
                      (s1_rd_we_q && (s1_rd_q != '0) && pending_q[s1_rd_q] && !cnd);
        out_valid   = s1_valid_q && !hazard;
        issue       = out_valid && out_ready;
        in_ready    = !s1_valid_q || issue;
        load        = in_valid && in_ready;
        rf_r1       = (load && reset_n) ? in_rs1 : s1_rs1_q;
        rf_r2       = (load && reset_n) ? in_rs2 : s1_rs2_q;
        out_rs1data = (s1_rs1_q == '0) ? '0 : cn1 ? wb_data : lw1 ? lw_data_q : rf_r1data;
        out_rs2data = (s1_rs2_q == '0) ? '0 : cn2 ? wb_data : lw2 ? lw_data_q : rf_r2data;
        out_rd      = s1_rd_q;
        out_rd_we   = s1_rd_we_q;
        out_tag     = s1_tag_q;
        s1_valid_d  = load ? 1'b1 : issue ? 1'b0 : s1_valid_q;
    end

    // Scoreboard next state: writeback clears, issue sets, set applied last so it wins
    always_comb begin
        pending_d = pending_q;
        if (wb_valid) pending_d[wb_rd] = 1'b0;
        if (issue && s1_rd_we_q) pending_d[s1_rd_q] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Holding slot, scoreboard and last-write capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_rd_q    <= '0;
            s1_rd_we_q <= 1'b0;
            s1_tag_q   <= '0;
            pending_q  <= '0;
            lw_valid_q <= 1'b0;
            lw_rd_q    <= '0;
            lw_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            pending_q  <= pending_d;
            lw_valid_q <= wb_valid;
            lw_rd_q    <= wb_rd;
            lw_data_q  <= wb_data;
            if (load) begin
                s1_rs1_q   <= in_rs1;
                s1_rs2_q   <= in_rs2;
                s1_rd_q    <= in_rd;
                s1_rd_we_q <= in_rd_we;
                s1_tag_q   <= in_tag;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed stimulus against a register-level model of operand_fetch plus literal spot checks.
module tb_operand_fetch;
    localparam int A = 5;
    localparam int C = 32;
    localparam int T = 32;
`ifdef OPFETCH_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0, reset_n = 1'b0;
    logic         in_valid = 1'b0, in_ready, in_rd_we = 1'b0;
    logic [A-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, rf_r1, rf_r2, wb_rd = '0, out_rd;
    logic [T-1:0] in_tag = '0, out_tag;
    logic [C-1:0] rf_r1data, rf_r2data, wb_data = '0, out_rs1data, out_rs2data;
    logic         wb_valid = 1'b0, out_valid, out_ready = 1'b1, out_rd_we;
    int           vecs = 0, errs = 0;

    always #5 clk = ~clk;

    operand_fetch #(.ADDR_SIZE(A), .CELL_SIZE(C), .TAG_W(T)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we), .in_tag(in_tag),
        .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_r1data(rf_r1data), .rf_r2data(rf_r2data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rs1data(out_rs1data),
        .out_rs2data(out_rs2data), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_tag(out_tag)
    );

    function automatic logic [C-1:0] init_val(input int i);
        return (i == 5) ? 32'h1234 : 32'h1000 + i;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Registered-read regfile environment: a read at an edge misses the write of that edge
    logic [C-1:0] mem [32];
    always @(posedge clk) begin
        rf_r1data <= mem[rf_r1];
        rf_r2data <= mem[rf_r2];
        if (!reset_n) for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        else if (wb_valid && wb_rd != 0) mem[wb_rd] <= wb_data;
    end

    // Model: architectural values, pending set and the held instruction
    logic [C-1:0] arch [32];
    logic         pend [32];
    logic         held = 1'b0, h_we = 1'b0;
    logic [A-1:0] h_rs1 = '0, h_rs2 = '0, h_rd = '0;
    logic [T-1:0] h_tag = '0;

    function automatic logic free_r(input logic [A-1:0] r);
        return (r == 0) || !pend[r] || (BYP && wb_valid && wb_rd == r);
    endfunction

    function automatic logic [C-1:0] val(input logic [A-1:0] r);
        return (r == 0) ? '0 : (BYP && wb_valid && wb_rd == r) ? wb_data : arch[r];
    endfunction

    always @(negedge clk) begin
        logic ov, ir, ld;
        if (!reset_n) begin
            cmp("rst_out_valid", out_valid, 0);
            cmp("rst_in_ready", in_ready, 1);
            cmp("rst_rf_r1", rf_r1, 0);
            cmp("rst_rf_r2", rf_r2, 0);
            cmp("rst_rs1data", out_rs1data, 0);
            cmp("rst_rs2data", out_rs2data, 0);
            cmp("rst_rd", out_rd, 0);
            cmp("rst_rd_we", out_rd_we, 0);
            cmp("rst_tag", out_tag, 0);
            held = 0; h_we = 0; h_rs1 = 0; h_rs2 = 0; h_rd = 0; h_tag = 0;
            for (int i = 0; i < 32; i++) begin
                pend[i] = 0;
                arch[i] = init_val(i);
            end
        end else begin
            ov = held && free_r(h_rs1) && free_r(h_rs2) && (!h_we || free_r(h_rd));
            ir = !held || (ov && out_ready);
            ld = in_valid && ir;
            cmp("out_valid", out_valid, ov);
            cmp("in_ready", in_ready, ir);
            cmp("rf_r1", rf_r1, ld ? in_rs1 : h_rs1);
            cmp("rf_r2", rf_r2, ld ? in_rs2 : h_rs2);
            if (ov) begin
                cmp("out_rs1data", out_rs1data, val(h_rs1));
                cmp("out_rs2data", out_rs2data, val(h_rs2));
                cmp("out_rd", out_rd, h_rd);
                cmp("out_rd_we", out_rd_we, h_we);
                cmp("out_tag", out_tag, h_tag);
            end
            if (wb_valid && wb_rd != 0) begin
                pend[wb_rd] = 0;
                arch[wb_rd] = wb_data;
            end
            if (ov && out_ready && h_we && h_rd != 0) pend[h_rd] = 1;
            if (ld) begin
                held = 1; h_rs1 = in_rs1; h_rs2 = in_rs2; h_rd = in_rd; h_we = in_rd_we; h_tag = in_tag;
            end else if (ov && out_ready) held = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [A-1:0] rs1, input logic [A-1:0] rs2, input logic [A-1:0] rd,
                       input logic we, input logic [T-1:0] tag);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we; in_tag = tag;
    endtask

    task automatic wb(input logic [A-1:0] rd, input logic [C-1:0] d);
        wb_valid = 1; wb_rd = rd; wb_data = d;
    endtask

    // Writeback already driven; report in which cycle (0 = writeback cycle) the bundle first becomes valid
    task automatic release_lat(output int lat, output logic [C-1:0] d1, output logic [C-1:0] d2);
        lat = -1; d1 = '0; d2 = '0;
        #1;
        if (out_valid) begin lat = 0; d1 = out_rs1data; d2 = out_rs2data; end
        tick();
        wb_valid = 0;
        #1;
        if (lat < 0 && out_valid) begin lat = 1; d1 = out_rs1data; d2 = out_rs2data; end
    endtask

    initial begin
        int lat;
        logic [C-1:0] d1, d2;
        tick(); tick();
        cmp("lit_rst_valid", out_valid, 0);
        cmp("lit_rst_ready", in_ready, 1);
        reset_n = 1;

        put(5, 0, 1, 0, 'hA1); tick(); in_valid = 0; #1;
        cmp("plain_valid", out_valid, 1);
        cmp("plain_rs1", out_rs1data, 32'h1234);
        cmp("plain_rs2", out_rs2data, 0);
        cmp("plain_tag", out_tag, 'hA1);
        tick();

        put(0, 0, 7, 1, 'hA2); tick();
        put(7, 0, 0, 0, 'hA3); tick(); in_valid = 0; #1;
        cmp("raw_stall", out_valid, 0);
        tick();
        cmp("raw_stall2", out_valid, 0);
        wb(7, 'hAA);
        release_lat(lat, d1, d2);
        cmp("raw_latency", lat, BYP ? 0 : 1);
        cmp("raw_data", d1, 'hAA);
        tick();

        put(0, 9, 0, 0, 'hA4); wb(9, 'h55); tick(); in_valid = 0; wb_valid = 0; #1;
        cmp("lw_valid", out_valid, 1);
        cmp("lw_rs2", out_rs2data, 'h55);
        tick();

        out_ready = 0;
        put(5, 9, 4, 1, 'hB0); tick();
        put(1, 0, 4, 1, 'hC0);
        for (int k = 0; k < 3; k++) begin
            #1;
            cmp("bp_valid", out_valid, 1);
            cmp("bp_in_ready", in_ready, 0);
            cmp("bp_tag", out_tag, 'hB0);
            cmp("bp_rs2", out_rs2data, 'h55);
            tick();
        end
        out_ready = 1; #1;
        cmp("bp_release_ready", in_ready, 1);
        tick(); in_valid = 0; #1;
        cmp("waw_stall", out_valid, 0);
        cmp("waw_tag", out_tag, 'hC0);
        tick();
        wb(4, 'h44); #1;
        cmp("waw_clear_valid", out_valid, BYP);
        put(4, 0, 0, 0, 'hD0);
        for (int k = 0; k < 4; k++) begin
            tick();
            wb_valid = 0;
            if (out_tag == 'hD0) break;
        end
        in_valid = 0; #1;
        cmp("setwins_tag", out_tag, 'hD0);
        cmp("setwins_stall", out_valid, 0);
        tick();
        cmp("setwins_stall2", out_valid, 0);
        wb(4, 'h77);
        release_lat(lat, d1, d2);
        cmp("setwins_latency", lat, BYP ? 0 : 1);
        cmp("setwins_data", d1, 'h77);
        tick();

        put(0, 0, 3, 1, 'hE0); tick();
        put(3, 3, 0, 0, 'hE1); tick(); in_valid = 0; #1;
        cmp("dual_stall", out_valid, 0);
        wb(0, 'hFF); tick(); wb_valid = 0; #1;
        cmp("wb0_stall", out_valid, 0);
        wb(3, 'h33);
        release_lat(lat, d1, d2);
        cmp("dual_latency", lat, BYP ? 0 : 1);
        cmp("dual_rs1", d1, 'h33);
        cmp("dual_rs2", d2, 'h33);
        tick();

        put(0, 0, 3, 1, 'hF0); tick();
        put(3, 0, 0, 0, 'hF1); tick(); in_valid = 0; #1;
        cmp("rst_pre_stall", out_valid, 0);
        reset_n = 0; #1;
        cmp("rst_mid_valid", out_valid, 0);
        cmp("rst_mid_ready", in_ready, 1);
        cmp("rst_mid_tag", out_tag, 0);
        tick();
        reset_n = 1;
        put(3, 0, 3, 1, 'hF2); tick(); in_valid = 0; #1;
        cmp("post_rst_valid", out_valid, 1);
        cmp("post_rst_rs1", out_rs1data, 32'h1003);
        cmp("post_rst_tag", out_tag, 'hF2);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage directly upstream of the register file; consumes decoded instructions and drives the regfile read addresses.
- Captures the 1-cycle-latency read data, bypasses in-flight writeback data, and tracks pending destination registers with a scoreboard.
- Presents complete operand bundles to execute over a valid/ready handshake.
- The writeback port is shared with the regfile write port (same rd/data/enable wires).

Parameters:
- ADDR_SIZE, 5, register address width; 2**ADDR_SIZE registers
- CELL_SIZE, 32, register data width
- TAG_W, 32, opaque instruction payload (opcode/imm/pc) carried alongside operands

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage can accept
- in_rs1  in  ADDR_SIZE  source 1
- in_rs2  in  ADDR_SIZE  source 2
- in_rd  in  ADDR_SIZE  destination
- in_rd_we  in  1  instruction writes rd
- in_tag  in  TAG_W  payload
- rf_r1  out  ADDR_SIZE  regfile read address 1
- rf_r2  out  ADDR_SIZE  regfile read address 2
- rf_r1data  in  CELL_SIZE  regfile data 1 (registered in regfile)
- rf_r2data  in  CELL_SIZE  regfile data 2
- wb_valid  in  1  writeback commits this cycle (regfile we)
- wb_rd  in  ADDR_SIZE  writeback register
- wb_data  in  CELL_SIZE  writeback data
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute accepts
- out_rs1data  out  CELL_SIZE  operand 1
- out_rs2data  out  CELL_SIZE  operand 2
- out_rd  out  ADDR_SIZE  destination
- out_rd_we  out  1  destination write enable
- out_tag  out  TAG_W  payload

Behaviour:
- Reset is asynchronous (reset_n low), active-low; clock is clk. Reset clears s1_valid, all pending bits and lw_valid.
- Outputs during reset: out_valid=0, in_ready=1, and all data outputs 0.
- Reset mid-operation drops the held instruction silently. No output is produced for it.
- One holding slot S1 stores s1_rs1, s1_rs2, s1_rd, s1_rd_we and s1_tag.
- in_ready = !s1_valid || (out_valid && out_ready). S1 loads from the inputs on in_valid && in_ready.
- Read addressing: rf_r1/rf_r2 = the next-cycle S1 source addresses, i.e. in_rs1/in_rs2 when a load occurs, else s1_rs1/s1_rs2.
  - Consequence: rf_r*data in the cycle after any edge always corresponds to the current S1 sources.
- Latency: accepted at edge E, the bundle is offered in cycle E+1 at the earliest.
- Last-write register: lw_valid/lw_rd/lw_data capture wb_* every edge.
  - Rationale: the regfile read at edge E misses a write committed at the same edge E.
- Operand select for rsN, in priority order:
  1. rsN==0 -> 0.
  2. wb_valid && wb_rd==rsN -> wb_data (only when the bypass is compiled in).
  3. lw_valid && lw_rd==rsN -> lw_data.
  4. Otherwise rf_rNdata.
- Scoreboard: pending[0..2**ADDR_SIZE-1]; pending[0] is always 0.
  - Set pending[s1_rd] on issue (out_valid && out_ready && s1_rd_we && s1_rd!=0).
  - Clear pending[wb_rd] on wb_valid.
  - Set and clear of the same register on the same edge: set wins.
- Hazard, where "cleared_now(r)" means the writeback bypass is compiled in && wb_valid && wb_rd==r:
  - RAW: for each source rsN!=0, pending[rsN] && !cleared_now(rsN).
  - WAW: s1_rd_we && s1_rd!=0 && pending[s1_rd] && !cleared_now(s1_rd).
- out_valid = s1_valid && !hazard. out_* come combinationally from S1 and the operand select.
- While stalled, S1 holds and re-reads every cycle; operands track newly committed writes.
- Both sources equal to the same pending register: a single clear releases both.
- wb_valid with wb_rd==0: no scoreboard effect and no bypass.

Optional Feature:
- Macro: OPFETCH_WB_BYPASS_EN
- Defined: same-cycle writeback bypass is active, and a cleared_now register releases the hazard in the writeback cycle.
- Undefined: no wb_data path. The instruction stalls until the edge that clears pending, then issues next cycle with data from lw_data.
  - Cost: +1 cycle per RAW hazard. Timing path wb_valid -> out_valid is removed.

Test Plan:
- Reset: assert reset_n=0 mid-stall with s1_valid=1 and pending[3]=1 -> out_valid=0, in_ready=1, pending all clear after release; next instruction issues without stall.
- Plain read: regfile x5=0x1234, issue rs1=5, rs2=0 at edge E -> out_valid in cycle E+1, out_rs1data=0x1234, out_rs2data=0.
- RAW: issue rd=7 we=1 and accept; next instruction has rs1=7, so out_valid=0. At cycle C, wb_valid wb_rd=7 wb_data=0xAA.
  - With bypass: out_valid=1 in C, out_rs1data=0xAA.
  - Without bypass: out_valid=1 in C+1, out_rs1data=0xAA.
- Same-edge write miss: wb x9=0x55 committed at the edge loading S1 (rs2=9, not pending) -> out_rs2data=0x55 via lw, not stale regfile data.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_* stable, no pending set; out_ready=1 -> one issue, pending set.
- WAW plus set-wins: pending[4]=1, S1 rd=4 we=1 -> stalled; wb x4 in same cycle as issue with bypass -> issues, pending[4] remains 1.
